// File: rtl/gf2m_digit_serial_mul_if.sv
// Operand/result handshake bundle for the GF(2^M) digit-serial multiplier.
// Request side: in_valid/in_ready with sq, a, b. Result side: out_valid/out_ready with p.
// The master drives requests and result acceptance; the slave is the multiplier.
interface gf2m_digit_serial_mul_if #(
  parameter int M = 233
);
  logic         in_valid;
  logic         in_ready;
  logic         sq;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] p;

  modport master (
    output in_valid, sq, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, sq, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/gf2m_digit_serial_mul.sv
// Digit-serial MSB-first GF(2^M) multiplier/squarer with reduction modulo x^M + POLY.
// Latency: exactly N = ceil(M/D) cycles from accept to out_valid, independent of data.
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module gf2m_digit_serial_mul #(
  parameter int           M    = 233,
  parameter int           D    = 16,
  parameter logic [M-1:0] POLY = (M'(1) << 74) | M'(1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gf2m_digit_serial_mul_if.slave bus
);

  localparam int N    = (M + D - 1) / D;
  localparam int NB   = N * D;
  localparam int W    = M + D;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  // Full modulus f(x) including the x^M term, widened to the working width.
  localparam logic [W-1:0] FW = {{D{1'b0}}, POLY} | (W'(1) << M);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [M-1:0]    a_q;
  logic [NB-1:0]   b_q;
  logic [M-1:0]    acc;
  logic [M-1:0]    acc_next;
  logic [CW-1:0]   cnt;
  logic [M-1:0]    p_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // One Horner step: acc*x^D plus a*digit, folded back below degree M.
  // Reduction is linear, so the shifted accumulator and the partial product
  // are summed first and folded once, top bit downwards.
  function automatic logic [M-1:0] horner_step(input logic [M-1:0] acc_i,
                                               input logic [M-1:0] a_i,
                                               input logic [D-1:0] dig);
    logic [W-1:0] t;
    t = {acc_i, {D{1'b0}}};
    for (int j = 0; j < D; j++) begin
      if (dig[j]) t = t ^ ({{D{1'b0}}, a_i} << j);
    end
    for (int i = W - 1; i >= M; i--) begin
      if (t[i]) t = t ^ (FW << (i - M));
    end
    return t[M-1:0];
  endfunction

  // Next accumulator from the current most-significant unconsumed digit.
  always_comb begin
    acc_next = horner_step(acc, a_q, b_q[NB-1 -: D]);
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            // Zero-extension on the left: padding digits are leading zeros MSB-first.
            b_q        <= NB'(bus.sq ? bus.a : bus.b);
            acc        <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          b_q <= b_q << D;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            p_q         <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// Bench for gf2m_digit_serial_mul: directed cases plus randomized ops checked
// against a schoolbook GF(2) multiply-then-reduce model, on three configurations
// (M=233/D=16, M=233/D=233, M=163/D=1 pentanomial).
module tb_gf2m_digit_serial_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  localparam logic [232:0] P233 = (233'd1 << 74) | 233'd1;
  localparam logic [162:0] P163 = 163'h0C9;  // x^7 + x^6 + x^3 + 1

  gf2m_digit_serial_mul_if #(.M(233)) if0 ();
  gf2m_digit_serial_mul_if #(.M(233)) if1 ();
  gf2m_digit_serial_mul_if #(.M(163)) if2 ();

  gf2m_digit_serial_mul #(.M(233), .D(16))  u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gf2m_digit_serial_mul #(.M(233), .D(233)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gf2m_digit_serial_mul #(.M(163), .D(1), .POLY(P163)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int ncmp  = 0;
  int nfail = 0;

  // Golden model: full polynomial product, then reduce with f = x^m + poly.
  function automatic logic [232:0] gmul(input logic [232:0] a, input logic [232:0] b,
                                        input int m, input logic [232:0] poly);
    logic [465:0] pr;
    logic [465:0] f;
    pr = '0;
    f  = 466'(poly) | (466'(1) << m);
    for (int i = 0; i < m; i++)
      if (b[i]) pr = pr ^ (466'(a) << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (pr[i]) pr = pr ^ (f << (i - m));
    return pr[232:0];
  endfunction

  function automatic logic [232:0] rnd(input int m);
    logic [255:0] r;
    logic [232:0] mask;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    mask = (233'(1) << m) - 233'(1);
    return r[232:0] & mask;
  endfunction

  task automatic check(input string tag, input logic [232:0] obs, input logic [232:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input int k, input logic v, input logic s,
                          input logic [232:0] a, input logic [232:0] b);
    case (k)
      0: begin if0.in_valid = v; if0.sq = s; if0.a = a; if0.b = b; end
      1: begin if1.in_valid = v; if1.sq = s; if1.a = a; if1.b = b; end
      default: begin if2.in_valid = v; if2.sq = s; if2.a = a[162:0]; if2.b = b[162:0]; end
    endcase
  endtask

  task automatic set_ordy(input int k, input logic v);
    case (k)
      0: if0.out_ready = v;
      1: if1.out_ready = v;
      default: if2.out_ready = v;
    endcase
  endtask

  function automatic logic rd_ir(input int k);
    case (k)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic rd_ov(input int k);
    case (k)
      0: return if0.out_valid;
      1: return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic [232:0] rd_p(input int k);
    case (k)
      0: return if0.p;
      1: return if1.p;
      default: return {70'd0, if2.p};
    endcase
  endfunction

  // One full transaction. in_valid stays high with junk operands through BUSY
  // and DONE (must be ignored); result is held `hold` cycles with out_ready=0.
  task automatic do_op(input int k, input logic [232:0] a, input logic [232:0] b,
                       input logic s, input int pre, input int hold,
                       output logic [232:0] res, output int lat);
    int w;
    drive_in(k, 1'b0, s, a, b);
    repeat (pre) step();
    drive_in(k, 1'b1, s, a, b);
    w = 0;
    while (!rd_ir(k) && w < 100) begin step(); w++; end
    step();  // accept edge
    drive_in(k, 1'b1, ~s, rnd(233), rnd(233));
    lat = 0;
    do begin step(); lat++; end while (!rd_ov(k) && lat < 2000);
    res = rd_p(k);
    for (int h = 0; h < hold; h++) begin
      drive_in(k, 1'b1, $urandom_range(0, 1), rnd(233), rnd(233));
      step();
      check("hold_p", rd_p(k), res);
      check("hold_ov", 233'(rd_ov(k)), 233'd1);
      check("hold_ir", 233'(rd_ir(k)), 233'd0);
    end
    drive_in(k, 1'b0, 1'b0, '0, '0);
    set_ordy(k, 1'b1);
    step();
    set_ordy(k, 1'b0);
    check("rel_ov", 233'(rd_ov(k)), 233'd0);
    check("rel_ir", 233'(rd_ir(k)), 233'd1);
  endtask

  initial begin
    logic [232:0] r;
    logic [232:0] ea;
    logic [232:0] eb;
    logic         es;
    int           lat;
    int           wt;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_in(k, 1'b0, 1'b0, '0, '0);
      set_ordy(k, 1'b0);
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check("rst_ir", 233'(rd_ir(k)), 233'd1);
      check("rst_ov", 233'(rd_ov(k)), 233'd0);
      check("rst_p", rd_p(k), 233'd0);
    end
    rst_n = 1'b1;
    step();

    // 1) 1*1 = 1, latency 15
    do_op(0, 233'd1, 233'd1, 1'b0, 0, 0, r, lat);
    check("one_p", r, 233'd1);
    check("one_lat", 233'(lat), 233'd15);

    // 2) x^232 * x = x^233 = x^74 + 1
    do_op(0, 233'd1 << 232, 233'd2, 1'b0, 1, 0, r, lat);
    check("wrap_p", r, P233);

    // 3) squaring ignores b
    do_op(0, 233'd1 << 116, '1, 1'b1, 0, 0, r, lat);
    check("sq116_p", r, 233'd1 << 232);
    do_op(0, 233'd1 << 232, 233'd5, 1'b1, 0, 0, r, lat);
    check("sq232_p", r, (233'd1 << 231) | (233'd1 << 146) | (233'd1 << 72));
    check("sq232_model", r, gmul(233'd1 << 232, 233'd1 << 232, 233, P233));

    // 4) result held 10 cycles under backpressure
    do_op(0, 233'h1234_5678_9abc, 233'hfeed_beef, 1'b0, 0, 10, r, lat);
    check("hold10_p", r, gmul(233'h1234_5678_9abc, 233'hfeed_beef, 233, P233));

    // 5) reset on the 5th BUSY cycle aborts the operation
    drive_in(0, 1'b1, 1'b0, 233'h77, 233'h99);
    wt = 0;
    while (!rd_ir(0) && wt < 100) begin step(); wt++; end
    step();
    drive_in(0, 1'b0, 1'b0, '0, '0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("abort_ov", 233'(rd_ov(0)), 233'd0);
    check("abort_ir", 233'(rd_ir(0)), 233'd1);
    check("abort_p", rd_p(0), 233'd0);
    step();
    rst_n = 1'b1;
    do_op(0, 233'd2, 233'd2, 1'b0, 0, 0, r, lat);
    check("post_rst_p", r, 233'd4);
    check("post_rst_lat", 233'(lat), 233'd15);

    // Boundary D=M: single-cycle BUSY
    do_op(1, 233'd1 << 232, 233'd2, 1'b0, 0, 0, r, lat);
    check("dm_p", r, P233);
    check("dm_lat", 233'(lat), 233'd1);

    // 6) randomized ops with gaps on each configuration
    for (int n = 0; n < 200; n++) begin
      ea = rnd(233); eb = rnd(233); es = 1'($urandom_range(0, 3) == 0);
      do_op(0, ea, eb, es, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
      check("rnd_d16_p", r, gmul(ea, es ? ea : eb, 233, P233));
      check("rnd_d16_lat", 233'(lat), 233'd15);
    end
    for (int n = 0; n < 200; n++) begin
      ea = rnd(233); eb = rnd(233); es = 1'($urandom_range(0, 3) == 0);
      do_op(1, ea, eb, es, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
      check("rnd_d233_p", r, gmul(ea, es ? ea : eb, 233, P233));
      check("rnd_d233_lat", 233'(lat), 233'd1);
    end
    for (int n = 0; n < 40; n++) begin
      ea = rnd(163); eb = rnd(163); es = 1'($urandom_range(0, 3) == 0);
      do_op(2, ea, eb, es, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
      check("rnd_m163_p", r, gmul(ea, es ? ea : eb, 163, 233'(P163)));
      check("rnd_m163_lat", 233'(lat), 233'd163);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
